// File: rtl/traffic_light_controller.sv
// Phase sequencer RED -> GREEN -> YELLOW with per-phase programmable durations.
// Optional feature macro PED_REQ_EN: pedestrian request may cut GREEN short after MIN_GREEN.
module traffic_light_controller #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned RED_DEF   = 4,
    parameter int unsigned GRN_DEF   = 6,
    parameter int unsigned YEL_DEF   = 2
`ifdef PED_REQ_EN
    ,
    parameter int unsigned MIN_GREEN = 2
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] red_time,
    input  logic [CNT_W-1:0] yellow_time,
    input  logic [CNT_W-1:0] green_time,
`ifdef PED_REQ_EN
    input  logic             ped_req,
`endif
    output logic             light_red,
    output logic             light_yellow,
    output logic             light_green,
    output logic [CNT_W-1:0] count,
    output logic             phase_done
);

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] RED_RST = CNT_W'(RED_DEF);
    localparam logic [CNT_W-1:0] GRN_RST = CNT_W'(GRN_DEF);
    localparam logic [CNT_W-1:0] YEL_RST = CNT_W'(YEL_DEF);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_red_q, shd_red_d;
    logic [CNT_W-1:0] shd_grn_q, shd_grn_d;
    logic [CNT_W-1:0] shd_yel_q, shd_yel_d;
    logic             done_q, done_d;
    logic             red_q, red_d;
    logic             yel_q, yel_d;
    logic             grn_q, grn_d;

    logic [CNT_W-1:0] eff_red, eff_grn, eff_yel;
    logic             match, ped_cut, advance;

    // A cfg_load coinciding with a transition feeds the entered phase directly.
    assign eff_red = cfg_load ? red_time    : shd_red_q;
    assign eff_grn = cfg_load ? green_time  : shd_grn_q;
    assign eff_yel = cfg_load ? yellow_time : shd_yel_q;

    assign match   = (count_q == act_q);
    assign advance = en && (match || ped_cut);

`ifdef PED_REQ_EN
    localparam logic [CNT_W-1:0] MIN_GRN_CNT = CNT_W'(MIN_GREEN);

    logic ped_pending_q, ped_pending_d;

    assign ped_cut = (state_q == ST_GREEN) && ped_pending_q && (count_q >= MIN_GRN_CNT);

    // Request is sticky; cleared when YELLOW is entered unless re-requested that cycle.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if ((state_d == ST_YELLOW) && (state_q != ST_YELLOW)) begin
            ped_pending_d = 1'b0;
        end
        if (ped_req) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pending_q <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
        end
    end
`else
    assign ped_cut = 1'b0;
`endif

    // Next-state, counter, active-time and lamp decode.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        act_d     = act_q;
        shd_red_d = shd_red_q;
        shd_grn_d = shd_grn_q;
        shd_yel_d = shd_yel_q;
        done_d    = 1'b0;

        if (cfg_load) begin
            shd_red_d = red_time;
            shd_grn_d = green_time;
            shd_yel_d = yellow_time;
        end

        if (advance) begin
            count_d = '0;
            done_d  = 1'b1;
            unique case (state_q)
                ST_RED: begin
                    state_d = ST_GREEN;
                    act_d   = eff_grn;
                end
                ST_GREEN: begin
                    state_d = ST_YELLOW;
                    act_d   = eff_yel;
                end
                default: begin
                    state_d = ST_RED;
                    act_d   = eff_red;
                end
            endcase
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end

        red_d = (state_d == ST_RED);
        grn_d = (state_d == ST_GREEN);
        yel_d = (state_d == ST_YELLOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RED;
            count_q   <= '0;
            act_q     <= RED_RST;
            shd_red_q <= RED_RST;
            shd_grn_q <= GRN_RST;
            shd_yel_q <= YEL_RST;
            done_q    <= 1'b0;
            red_q     <= 1'b1;
            yel_q     <= 1'b0;
            grn_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            act_q     <= act_d;
            shd_red_q <= shd_red_d;
            shd_grn_q <= shd_grn_d;
            shd_yel_q <= shd_yel_d;
            done_q    <= done_d;
            red_q     <= red_d;
            yel_q     <= yel_d;
            grn_q     <= grn_d;
        end
    end

    assign light_red    = red_q;
    assign light_yellow = yel_q;
    assign light_green  = grn_q;
    assign count        = count_q;
    assign phase_done   = done_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed, table-driven bench for traffic_light_controller; vectors carry inputs and
// the hand-computed lamps/count/phase_done after the following rising edge.
module tb_traffic_light_controller;

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;

    typedef struct {
        logic       en;
        logic       cfg;
        logic [3:0] r;
        logic [3:0] y;
        logic [3:0] g;
        logic [2:0] lamps;
        logic [3:0] cnt;
        logic       pd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] red_time = '0;
    logic [3:0] yellow_time = '0;
    logic [3:0] green_time = '0;
`ifdef PED_REQ_EN
    logic       ped_req = 1'b0;
`endif
    logic       light_red, light_yellow, light_green, phase_done;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    traffic_light_controller dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_load     (cfg_load),
        .red_time     (red_time),
        .yellow_time  (yellow_time),
        .green_time   (green_time),
`ifdef PED_REQ_EN
        .ped_req      (ped_req),
`endif
        .light_red    (light_red),
        .light_yellow (light_yellow),
        .light_green  (light_green),
        .count        (count),
        .phase_done   (phase_done)
    );

    function automatic logic [7:0] obs();
        return {light_red, light_yellow, light_green, count, phase_done};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] exp);
        logic [7:0] got;
        got = obs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got ryg=%b cnt=%0d pd=%b, expected ryg=%b cnt=%0d pd=%b",
                     nm, idx, got[7:5], got[4:1], got[0], exp[7:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic add(input logic e, input logic c, input logic [3:0] r, input logic [3:0] y,
                       input logic [3:0] g, input logic [2:0] l, input logic [3:0] n,
                       input logic p);
        vec_t v;
        v.en = e; v.cfg = c; v.r = r; v.y = y; v.g = g;
        v.lamps = l; v.cnt = n; v.pd = p;
        tbl.push_back(v);
    endtask

    // Plain enabled step; junk times expose any use of *_time without cfg_load.
    task automatic nx(input logic [2:0] l, input logic [3:0] n, input logic p);
        add(1'b1, 1'b0, 4'hF, 4'hF, 4'hF, l, n, p);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            en          = tbl[i].en;
            cfg_load    = tbl[i].cfg;
            red_time    = tbl[i].r;
            yellow_time = tbl[i].y;
            green_time  = tbl[i].g;
            @(posedge clk);
            @(negedge clk);
            chk("vec", i, {tbl[i].lamps, tbl[i].cnt, tbl[i].pd});
        end
        en       = 1'b0;
        cfg_load = 1'b0;
    endtask

`ifdef PED_REQ_EN
    task automatic ped_step(input int idx, input logic p, input logic [2:0] l,
                            input logic [3:0] n, input logic d);
        en = 1'b1; cfg_load = 1'b0; ped_req = p;
        @(posedge clk);
        @(negedge clk);
        chk("ped", idx, {l, n, d});
        ped_req = 1'b0;
    endtask
`endif

    int split;

    initial begin
        // Default sequence from reset: red 5, green 7, yellow 3.
        for (int i = 1; i <= 4; i++) nx(LR, 4'(i), 1'b0);
        nx(LG, 4'd0, 1'b1);
        for (int i = 1; i <= 6; i++) nx(LG, 4'(i), 1'b0);
        nx(LY, 4'd0, 1'b1); nx(LY, 4'd1, 1'b0); nx(LY, 4'd2, 1'b0);
        nx(LR, 4'd0, 1'b1);
        // Reach GREEN count 3, freeze 10 cycles, resume at 4.
        for (int i = 1; i <= 4; i++) nx(LR, 4'(i), 1'b0);
        nx(LG, 4'd0, 1'b1);
        for (int i = 1; i <= 3; i++) nx(LG, 4'(i), 1'b0);
        for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 4'hF, 4'hF, 4'hF, LG, 4'd3, 1'b0);
        nx(LG, 4'd4, 1'b0); nx(LG, 4'd5, 1'b0); nx(LG, 4'd6, 1'b0);
        nx(LY, 4'd0, 1'b1); nx(LY, 4'd1, 1'b0); nx(LY, 4'd2, 1'b0);
        nx(LR, 4'd0, 1'b1);
        // green_time=1 loaded mid-red: red still 5 cycles, next green 2.
        nx(LR, 4'd1, 1'b0); nx(LR, 4'd2, 1'b0);
        add(1'b1, 1'b1, 4'd4, 4'd2, 4'd1, LR, 4'd3, 1'b0);
        nx(LR, 4'd4, 1'b0);
        nx(LG, 4'd0, 1'b1); nx(LG, 4'd1, 1'b0);
        nx(LY, 4'd0, 1'b1); nx(LY, 4'd1, 1'b0); nx(LY, 4'd2, 1'b0);
        nx(LR, 4'd0, 1'b1);
        // yellow_time=0 loaded on the GREEN->YELLOW edge: 1-cycle yellow.
        for (int i = 1; i <= 4; i++) nx(LR, 4'(i), 1'b0);
        nx(LG, 4'd0, 1'b1);
        nx(LG, 4'd1, 1'b0);
        add(1'b1, 1'b1, 4'd4, 4'd0, 4'd1, LY, 4'd0, 1'b1);
        nx(LR, 4'd0, 1'b1);
        // Program green=3, run into YELLOW count 0 for the reset case.
        add(1'b1, 1'b1, 4'd4, 4'd2, 4'd3, LR, 4'd1, 1'b0);
        for (int i = 2; i <= 4; i++) nx(LR, 4'(i), 1'b0);
        nx(LG, 4'd0, 1'b1);
        for (int i = 1; i <= 3; i++) nx(LG, 4'(i), 1'b0);
        nx(LY, 4'd0, 1'b1);
        split = tbl.size();
        // After reset the defaults return: green is 7 cycles again.
        for (int i = 1; i <= 4; i++) nx(LR, 4'(i), 1'b0);
        nx(LG, 4'd0, 1'b1);
        for (int i = 1; i <= 6; i++) nx(LG, 4'(i), 1'b0);
        nx(LY, 4'd0, 1'b1); nx(LY, 4'd1, 1'b0); nx(LY, 4'd2, 1'b0);
        nx(LR, 4'd0, 1'b1);

        repeat (2) @(negedge clk);
        chk("reset", 0, {LR, 4'd0, 1'b0});
        rst = 1'b0;

        run_range(0, split);

        // Asynchronous reset between edges while YELLOW with phase_done high.
        #2 rst = 1'b1;
        #1 chk("async_rst", 0, {LR, 4'd0, 1'b0});
        @(negedge clk);
        chk("async_rst", 1, {LR, 4'd0, 1'b0});
        rst = 1'b0;

        run_range(split, tbl.size());

`ifdef PED_REQ_EN
        // ped_req at GREEN count 0 cuts green after count 2; pending then clears.
        for (int i = 1; i <= 4; i++) ped_step(i, 1'b0, LR, 4'(i), 1'b0);
        ped_step(5, 1'b0, LG, 4'd0, 1'b1);
        ped_step(6, 1'b1, LG, 4'd1, 1'b0);
        ped_step(7, 1'b0, LG, 4'd2, 1'b0);
        ped_step(8, 1'b0, LY, 4'd0, 1'b1);
        ped_step(9, 1'b0, LY, 4'd1, 1'b0);
        ped_step(10, 1'b0, LY, 4'd2, 1'b0);
        ped_step(11, 1'b0, LR, 4'd0, 1'b1);
        for (int i = 1; i <= 4; i++) ped_step(11 + i, 1'b0, LR, 4'(i), 1'b0);
        ped_step(16, 1'b0, LG, 4'd0, 1'b1);
        for (int i = 1; i <= 6; i++) ped_step(16 + i, 1'b0, LG, 4'(i), 1'b0);
        ped_step(23, 1'b0, LY, 4'd0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
